// File: rtl/seq_alu_core.sv
// Multi-cycle register-file processor: one instruction in flight, valid/ready accept,
// READ -> (EXEC) -> WB -> DONE sequencing with a configurable ALU latency.
module seq_alu_core #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned ALU_LAT = 16,
  localparam int unsigned ADDR_W  = $clog2(NREGS),
  localparam int unsigned INSTR_W = 3 + 3 * ADDR_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  out1,
  output logic [DATA_W-1:0]  out2,
  output logic [DATA_W-1:0]  alu_res,
  output logic               carry
);

  localparam int unsigned SH_W  = $clog2(DATA_W);
  localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(ALU_LAT - 1);

  localparam logic [2:0] OpLdi = 3'b000;
  localparam logic [2:0] OpRd1 = 3'b001;
  localparam logic [2:0] OpRd2 = 3'b010;
  localparam logic [2:0] OpAnd = 3'b100;
  localparam logic [2:0] OpAdd = 3'b101;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpShl = 3'b111;

  typedef enum logic [2:0] {StIdle, StRead, StExec, StWb, StDone} state_e;

  state_e              state_q;
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   opa_q, opb_q, res_q, out1_q, out2_q, alu_res_q;
  logic                res_c_q, carry_q, done_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [2:0]          op;
  logic [ADDR_W-1:0]   rd, rs1, rs2;
  logic [DATA_W-1:0]   imm;
  logic [SH_W-1:0]     shamt;
  logic [DATA_W:0]     sum, diff;
  logic [DATA_W-1:0]   res_d, wb_val;
  logic                res_c_d, wb_c, wr_en;

  assign op    = instr_q[INSTR_W-1 -: 3];
  assign rd    = instr_q[DATA_W + 3 * ADDR_W - 1 -: ADDR_W];
  assign rs1   = instr_q[DATA_W + 2 * ADDR_W - 1 -: ADDR_W];
  assign rs2   = instr_q[DATA_W + ADDR_W - 1 -: ADDR_W];
  assign imm   = instr_q[DATA_W-1:0];
  assign shamt = imm[SH_W-1:0];

  // Subtraction's top bit is the unsigned borrow, i.e. opa < opb.
  assign sum  = {1'b0, opa_q} + {1'b0, opb_q};
  assign diff = {1'b0, opa_q} - {1'b0, opb_q};

  always_comb begin
    res_d   = '0;
    res_c_d = 1'b0;
    case (op)
      OpAnd:   res_d = opa_q & opb_q;
      OpAdd:   {res_c_d, res_d} = sum;
      OpSub:   {res_c_d, res_d} = diff;
      OpShl:   res_d = opa_q << shamt;
      default: res_d = '0;
    endcase
  end

  always_comb begin
    wr_en  = (op != OpRd1) && (op != OpRd2);
    wb_val = op[2] ? res_q : ((op == OpLdi) ? imm : opa_q);
    wb_c   = op[2] ? res_c_q : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      regs_q    <= '{default: '0};
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      res_c_q   <= 1'b0;
      out1_q    <= '0;
      out2_q    <= '0;
      alu_res_q <= '0;
      carry_q   <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (instr_valid) begin
            instr_q <= instr;
            state_q <= StRead;
          end
        end
        StRead: begin
          opa_q <= regs_q[rs1];
          opb_q <= regs_q[rs2];
          if (op != OpLdi) out1_q <= regs_q[rs1];
          if ((op == OpRd2) || (op == OpAnd) || (op == OpAdd) || (op == OpSub)) begin
            out2_q <= regs_q[rs2];
          end
          cnt_q   <= CntLoad;
          state_q <= op[2] ? StExec : StWb;
        end
        StExec: begin
          if (cnt_q == '0) begin
            res_q   <= res_d;
            res_c_q <= res_c_d;
            state_q <= StWb;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StWb: begin
          if (wr_en) begin
            regs_q[rd] <= wb_val;
            alu_res_q  <= wb_val;
            carry_q    <= wb_c;
          end
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign instr_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign out1        = out1_q;
  assign out2        = out2_q;
  assign alu_res     = alu_res_q;
  assign carry       = carry_q;

endmodule

// File: tb/tb_seq_alu_core.sv
// Directed bench for seq_alu_core: default configuration plus a small 8-bit/8-reg/1-cycle one.
module tb_seq_alu_core;

  localparam logic [2:0] LDI = 3'b000, RD1 = 3'b001, RD2 = 3'b010, MOV = 3'b011;
  localparam logic [2:0] AND = 3'b100, ADD = 3'b101, SUB = 3'b110, SHL = 3'b111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults (16-bit, 32 regs, ALU_LAT 16)
  logic        a_rst = 1'b0, a_valid = 1'b0;
  logic [33:0] a_instr = '0;
  logic        a_ready, a_busy, a_done, a_carry;
  logic [15:0] a_out1, a_out2, a_res;

  seq_alu_core dut_a (
    .clk         (clk),
    .rst         (a_rst),
    .instr       (a_instr),
    .instr_valid (a_valid),
    .instr_ready (a_ready),
    .busy        (a_busy),
    .done        (a_done),
    .out1        (a_out1),
    .out2        (a_out2),
    .alu_res     (a_res),
    .carry       (a_carry)
  );

  // Instance B: 8-bit, 8 regs, ALU_LAT 1
  logic        b_rst = 1'b0, b_valid = 1'b0;
  logic [19:0] b_instr = '0;
  logic        b_ready, b_busy, b_done, b_carry;
  logic [7:0]  b_out1, b_out2, b_res;

  seq_alu_core #(.DATA_W(8), .NREGS(8), .ALU_LAT(1)) dut_b (
    .clk         (clk),
    .rst         (b_rst),
    .instr       (b_instr),
    .instr_valid (b_valid),
    .instr_ready (b_ready),
    .busy        (b_busy),
    .done        (b_done),
    .out1        (b_out1),
    .out2        (b_out2),
    .alu_res     (b_res),
    .carry       (b_carry)
  );

  // Issue one instruction on A and check handshake, busy/ready and done latency.
  task automatic run_a(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [15:0] imm, input int exp_lat,
                       input string name);
    int n;
    n = 0;
    while (!a_ready && n < 100) begin @(posedge clk); #1; n++; end
    a_instr = {op, rd, rs1, rs2, imm};
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    a_instr = '0;
    checks++;
    if ({a_ready, a_busy} !== 2'b01) begin
      errors++;
      $display("FAIL %s accept: ready/busy=%b required 01", name, {a_ready, a_busy});
    end
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (a_ready !== 1'b0) begin
        checks++; errors++;
        $display("FAIL %s ready_low: ready=%b at edge %0d required 0", name, a_ready, n);
      end
    end while (a_done !== 1'b1 && n < 200);
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL %s latency: done after %0d edges required %0d", name, n, exp_lat);
    end
    @(posedge clk); #1;
    checks++;
    if ({a_ready, a_busy, a_done} !== 3'b100) begin
      errors++;
      $display("FAIL %s idle: ready/busy/done=%b required 100", name, {a_ready, a_busy, a_done});
    end
  endtask

  task automatic run_b(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [7:0] imm, input int exp_lat,
                       input string name);
    int n;
    n = 0;
    while (!b_ready && n < 100) begin @(posedge clk); #1; n++; end
    b_instr = {op, rd, rs1, rs2, imm};
    b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    b_instr = '0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (b_done !== 1'b1 && n < 50);
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL %s latency: done after %0d edges required %0d", name, n, exp_lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_a_reset(input string name);
    checks++;
    if ({a_ready, a_busy, a_done, a_carry} !== 4'b1000 || {a_out1, a_out2, a_res} !== 48'h0) begin
      errors++;
      $display("FAIL %s: rdy/bsy/dn/c=%b out1=%h out2=%h res=%h required 1000 0 0 0", name,
               {a_ready, a_busy, a_done, a_carry}, a_out1, a_out2, a_res);
    end
  endtask

  task automatic test_reset;
    a_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 a_rst = 1'b0;
    check_a_reset("reset_state");
  endtask

  task automatic test_ldi_rd1;
    run_a(LDI, 5'd3, 5'd0, 5'd0, 16'h1234, 2, "ldi_r3");
    checks++;
    if ({a_res, a_carry} !== {16'h1234, 1'b0}) begin
      errors++; $display("FAIL ldi_r3: res=%h c=%b required 1234 0", a_res, a_carry);
    end
    run_a(RD1, 5'd0, 5'd3, 5'd3, 16'h0, 2, "rd1_r3");
    checks++;
    if ({a_out1, a_out2, a_res} !== {16'h1234, 16'h0000, 16'h1234}) begin
      errors++;
      $display("FAIL rd1_r3: out1=%h out2=%h res=%h required 1234 0000 1234", a_out1, a_out2, a_res);
    end
  endtask

  task automatic test_add;
    run_a(LDI, 5'd1, 5'd0, 5'd0, 16'hFFFF, 2, "ldi_r1");
    run_a(LDI, 5'd2, 5'd0, 5'd0, 16'h0001, 2, "ldi_r2");
    run_a(ADD, 5'd4, 5'd1, 5'd2, 16'h0, 18, "add_r4");
    checks++;
    if ({a_res, a_carry} !== {16'h0000, 1'b1}) begin
      errors++; $display("FAIL add_r4: res=%h c=%b required 0000 1", a_res, a_carry);
    end
    run_a(RD2, 5'd0, 5'd4, 5'd1, 16'h0, 2, "rd2_r4_r1");
    checks++;
    if ({a_out1, a_out2, a_carry} !== {16'h0000, 16'hFFFF, 1'b1}) begin
      errors++;
      $display("FAIL rd2_r4_r1: out1=%h out2=%h c=%b required 0000 ffff 1", a_out1, a_out2, a_carry);
    end
  endtask

  task automatic test_sub;
    run_a(SUB, 5'd5, 5'd2, 5'd1, 16'h0, 18, "sub_borrow");
    checks++;
    if ({a_res, a_carry} !== {16'h0002, 1'b1}) begin
      errors++; $display("FAIL sub_borrow: res=%h c=%b required 0002 1", a_res, a_carry);
    end
    run_a(SUB, 5'd5, 5'd1, 5'd2, 16'h0, 18, "sub_noborrow");
    checks++;
    if ({a_res, a_carry, a_out2} !== {16'hFFFE, 1'b0, 16'h0001}) begin
      errors++;
      $display("FAIL sub_noborrow: res=%h c=%b out2=%h required fffe 0 0001", a_res, a_carry, a_out2);
    end
  endtask

  task automatic test_shl_mov_and;
    run_a(SHL, 5'd8, 5'd2, 5'd1, 16'h000F, 18, "shl_15");
    checks++;
    if ({a_res, a_carry, a_out2} !== {16'h8000, 1'b0, 16'h0001}) begin
      errors++;
      $display("FAIL shl_15: res=%h c=%b out2=%h required 8000 0 0001", a_res, a_carry, a_out2);
    end
    run_a(SHL, 5'd8, 5'd2, 5'd1, 16'h0010, 18, "shl_wrap");
    checks++;
    if (a_res !== 16'h0001) begin
      errors++; $display("FAIL shl_wrap: res=%h required 0001", a_res);
    end
    run_a(LDI, 5'd6, 5'd0, 5'd0, 16'hABCD, 2, "ldi_r6");
    run_a(MOV, 5'd6, 5'd6, 5'd0, 16'h0, 2, "mov_self");
    run_a(RD1, 5'd0, 5'd6, 5'd0, 16'h0, 2, "rd1_r6");
    checks++;
    if ({a_out1, a_res} !== {16'hABCD, 16'hABCD}) begin
      errors++; $display("FAIL mov_self: out1=%h res=%h required abcd abcd", a_out1, a_res);
    end
    run_a(LDI, 5'd9, 5'd0, 5'd0, 16'h0FF0, 2, "ldi_r9");
    run_a(LDI, 5'd10, 5'd0, 5'd0, 16'h3C3C, 2, "ldi_r10");
    run_a(AND, 5'd9, 5'd9, 5'd10, 16'h0, 18, "and_inplace");
    run_a(RD1, 5'd0, 5'd9, 5'd0, 16'h0, 2, "rd1_r9");
    checks++;
    if ({a_out1, a_res, a_carry} !== {16'h0C30, 16'h0C30, 1'b0}) begin
      errors++;
      $display("FAIL and_inplace: out1=%h res=%h c=%b required 0c30 0c30 0", a_out1, a_res, a_carry);
    end
  endtask

  // instr_valid held high while busy: only what is present at ready=1 executes.
  task automatic test_back_to_back;
    int n;
    a_valid = 1'b1;
    a_instr = {LDI, 5'd11, 5'd0, 5'd0, 16'h1111};
    @(posedge clk); #1;
    for (int k = 1; k <= 3; k++) begin
      a_instr = {LDI, 5'd12, 5'd0, 5'd0, 16'hDE00 + 16'(k)};
      @(posedge clk); #1;
      checks++;
      if (a_ready !== (k == 3)) begin
        errors++; $display("FAIL b2b_ready: ready=%b after E%0d required %0d", a_ready, k, k == 3);
      end
    end
    a_instr = {LDI, 5'd13, 5'd0, 5'd0, 16'h3333};
    @(posedge clk); #1;
    a_instr = {LDI, 5'd12, 5'd0, 5'd0, 16'hBEEF};
    checks++;
    if (a_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_accept2: ready=%b required 0", a_ready);
    end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (a_done !== 1'b1 && n < 50);
    a_valid = 1'b0;
    checks++;
    if (n != 2 || a_res !== 16'h3333) begin
      errors++; $display("FAIL b2b_second: edges=%0d res=%h required 2 3333", n, a_res);
    end
    @(posedge clk); #1;
    run_a(RD2, 5'd0, 5'd11, 5'd13, 16'h0, 2, "rd2_r11_r13");
    checks++;
    if ({a_out1, a_out2} !== {16'h1111, 16'h3333}) begin
      errors++; $display("FAIL b2b_regs: r11=%h r13=%h required 1111 3333", a_out1, a_out2);
    end
    run_a(RD1, 5'd0, 5'd12, 5'd0, 16'h0, 2, "rd1_r12");
    checks++;
    if (a_out1 !== 16'h0000) begin
      errors++; $display("FAIL b2b_ignored: r12=%h required 0000", a_out1);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    a_instr = {ADD, 5'd7, 5'd1, 5'd2, 16'h0};
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0;
    check_a_reset("reset_exec");
    seen = 0;
    repeat (25) begin @(posedge clk); #1; if (a_done || a_busy) seen++; end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_exec_quiet: active cycles=%0d required 0", seen);
    end
    run_a(RD2, 5'd0, 5'd7, 5'd1, 16'h0, 2, "rd2_r7_r1");
    checks++;
    if ({a_out1, a_out2} !== 32'h0) begin
      errors++; $display("FAIL reset_exec_regs: r7=%h r1=%h required 0000 0000", a_out1, a_out2);
    end
    // reset and valid on the same edge: reset wins
    a_rst = 1'b1;
    a_valid = 1'b1;
    a_instr = {LDI, 5'd14, 5'd0, 5'd0, 16'h7777};
    @(posedge clk); #1;
    a_rst = 1'b0;
    a_valid = 1'b0;
    check_a_reset("reset_with_valid");
    run_a(RD1, 5'd0, 5'd14, 5'd0, 16'h0, 2, "rd1_r14");
    checks++;
    if (a_out1 !== 16'h0000) begin
      errors++; $display("FAIL reset_with_valid_reg: r14=%h required 0000", a_out1);
    end
  endtask

  task automatic test_small_cfg;
    b_rst = 1'b1;
    @(posedge clk); #1;
    b_rst = 1'b0;
    run_b(LDI, 3'd1, 3'd0, 3'd0, 8'hFF, 2, "b_ldi_r1");
    run_b(LDI, 3'd2, 3'd0, 3'd0, 8'h01, 2, "b_ldi_r2");
    run_b(ADD, 3'd3, 3'd1, 3'd2, 8'h00, 3, "b_add");
    checks++;
    if ({b_res, b_carry} !== {8'h00, 1'b1}) begin
      errors++; $display("FAIL b_add: res=%h c=%b required 00 1", b_res, b_carry);
    end
    run_b(RD2, 3'd0, 3'd3, 3'd1, 8'h00, 2, "b_rd2");
    checks++;
    if ({b_out1, b_out2} !== {8'h00, 8'hFF}) begin
      errors++; $display("FAIL b_rd2: out1=%h out2=%h required 00 ff", b_out1, b_out2);
    end
    b_instr = {ADD, 3'd7, 3'd1, 3'd2, 8'h00};
    b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(posedge clk); #1;
    b_rst = 1'b1;
    @(posedge clk); #1;
    b_rst = 1'b0;
    checks++;
    if ({b_ready, b_busy, b_done, b_carry} !== 4'b1000 || {b_out1, b_out2, b_res} !== 24'h0) begin
      errors++;
      $display("FAIL b_reset_exec: rdy/bsy/dn/c=%b out1=%h out2=%h res=%h required 1000 0 0 0",
               {b_ready, b_busy, b_done, b_carry}, b_out1, b_out2, b_res);
    end
    run_b(RD1, 3'd0, 3'd7, 3'd0, 8'h00, 2, "b_rd1_r7");
    checks++;
    if (b_out1 !== 8'h00) begin
      errors++; $display("FAIL b_reset_exec_reg: r7=%h required 00", b_out1);
    end
  endtask

  initial begin
    b_rst = 1'b1;
    #1;
    test_reset();
    test_ldi_rd1();
    test_add();
    test_sub();
    test_shl_mov_and();
    test_back_to_back();
    test_reset_mid();
    test_small_cfg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
